// File: rtl/kernel_bc_fifo_param_flags.sv
`default_nettype none
// ============================================================================
// Module      : kernel_bc_fifo_param_flags
// Description : Show-ahead single-clock FIFO, any depth, with count,
//               registered threshold flags, flush and sticky error flags.
// Revision    : 1.0
// ============================================================================
module kernel_bc_fifo_param_flags #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  C_CW         = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH      = C_CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF_LVL     = C_CW'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] C_AE_LVL     = C_CW'(AE_MARGIN);
  localparam logic [ADDR_WIDTH-1:0] C_LAST     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic                C_AF_AT_ZERO = (AF_MARGIN >= DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  r_full_n;
  logic                  r_empty_n;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_ovf_set;
  logic                  w_udf_set;

  // Flush wins over any handshake in the same cycle.
  assign w_wr_en   = r_full_n  & if_write_ce & if_write & ~flush;
  assign w_rd_en   = r_empty_n & if_read_ce  & if_read  & ~flush;
  assign w_ovf_set = if_write_ce & if_write & ~r_full_n;
  assign w_udf_set = if_read_ce  & if_read  & ~r_empty_n;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_wr_en && !w_rd_en)
      w_count_nxt = r_count + 1'b1;
    else if (!w_wr_en && w_rd_en)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wptr] <= if_din;
  end

  // Flags derive from the next count so they line up with if_count.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_af      <= C_AF_AT_ZERO;
      r_ae      <= 1'b1;
    end else begin
      if (w_wr_en) r_wptr <= ptr_inc(r_wptr);
      if (w_rd_en) r_rptr <= ptr_inc(r_rptr);
      r_count   <= w_count_nxt;
      r_full_n  <= (w_count_nxt != C_DEPTH);
      r_empty_n <= (w_count_nxt != '0);
      r_af      <= (w_count_nxt >= C_AF_LVL);
      r_ae      <= (w_count_nxt <= C_AE_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow  <= 1'b1;
      else if (err_clr) r_overflow  <= 1'b0;
      if (w_udf_set)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  assign if_dout         = r_mem[r_rptr];
  assign if_full_n       = r_full_n;
  assign if_empty_n      = r_empty_n;
  assign if_count        = r_count;
  assign if_almost_full  = r_af;
  assign if_almost_empty = r_ae;
  assign overflow        = r_overflow;
  assign underflow       = r_underflow;

endmodule
`default_nettype wire
